i2c_cmd_engine: RTL and testbench

//  Executes one I2C byte-level command per request: INITIALIZE, START, WRITE, READ or STOP.

---
 rtl/i2c_cmd_engine_pkg.sv | 76 +++++++
 rtl/i2c_wb_port.sv | 63 ++++++
 rtl/i2c_cmd_engine.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_cmd_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_engine_pkg.sv
// Shared definitions for the I2C command engine: opcodes, core register map,
// status bits, FSM state type and the per-command register write sequence.
package i2c_cmd_engine_pkg;

  // Upstream opcodes
  localparam logic [2:0] OP_INITIALIZE = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_WRITE      = 3'd2;
  localparam logic [2:0] OP_READ       = 3'd3;
  localparam logic [2:0] OP_STOP       = 3'd4;

  // i2c_master_top register addresses (TXR/RXR and CR/SR share addresses)
  localparam logic [2:0] REG_PRER_LO = 3'd0;
  localparam logic [2:0] REG_PRER_HI = 3'd1;
  localparam logic [2:0] REG_CTR     = 3'd2;
  localparam logic [2:0] REG_TXR     = 3'd3;
  localparam logic [2:0] REG_RXR     = 3'd3;
  localparam logic [2:0] REG_CR      = 3'd4;
  localparam logic [2:0] REG_SR      = 3'd4;

  // Status register bit positions
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [15:0] PRESCALE_DEF       = 16'd399;
  localparam logic [23:0] TIMEOUT_CYCLES_DEF = 24'd2_000_000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB_WR  = 3'd1,
    S_POLL   = 3'd2,
    S_RD_RXR = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // One register write of a command sequence; last marks the final write.
  typedef struct packed {
    logic       last;
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_step_t;

  // CR encodings: STA=0x80 STO=0x40 RD=0x20 WR=0x10 ACK=0x08
  function automatic wb_step_t seq_step(input logic [2:0]  op,
                                        input logic [1:0]  step,
                                        input logic        fun,
                                        input logic [6:0]  addr,
                                        input logic [7:0]  wdat,
                                        input logic [15:0] prescale);
    wb_step_t s;
    s = '0;
    case (op)
      OP_INITIALIZE: begin
        case (step)
          2'd0:    s = '{1'b0, REG_PRER_LO, prescale[7:0]};
          2'd1:    s = '{1'b0, REG_PRER_HI, prescale[15:8]};
          default: s = '{1'b1, REG_CTR, 8'h80};
        endcase
      end
      OP_START: begin
        if (step == 2'd0) s = '{1'b0, REG_TXR, {addr, ~fun}};
        else              s = '{1'b1, REG_CR, 8'h90};
      end
      OP_WRITE: begin
        if (step == 2'd0) s = '{1'b0, REG_TXR, wdat};
        else              s = '{1'b1, REG_CR, fun ? 8'h50 : 8'h10};
      end
      OP_READ:  s = '{1'b1, REG_CR, fun ? 8'h28 : 8'h20};
      default:  s = '{1'b1, REG_CR, 8'h40};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2c_wb_port.sv
// Single-transfer Wishbone master. A go pulse while idle launches one access;
// done pulses the cycle after the ack, so back-to-back requests always leave
// at least one idle bus cycle.
module i2c_wb_port (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       done_o,
  output logic [7:0] rdat_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic [7:0] rdat_q;

  // Launch on go, hold address/data until ack, drop the strobe after the ack cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wb_ack_i) begin
          cyc_q  <= 1'b0;
          done_q <= 1'b1;
          rdat_q <= wb_dat_i;
        end
      end else if (go_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdat_i;
      end
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign done_o   = done_q;
  assign rdat_o   = rdat_q;

endmodule

// File: rtl/i2c_cmd_engine.sv
// I2C byte-command engine: turns one upstream command into register accesses
// on the i2c_master_top core. Optional poll watchdog: I2C_CMD_TIMEOUT_EN.
// Upstream handshake: a request transfers on req_val & req_rdy (req_rdy only in
// IDLE); a response is offered with resp_val and its data holds until
// resp_val & resp_rdy, after which the engine is back in IDLE next cycle.
module i2c_cmd_engine
  import i2c_cmd_engine_pkg::*;
#(
  parameter logic [15:0] PRESCALE = PRESCALE_DEF
`ifdef I2C_CMD_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] addr,
  input  logic [7:0] write_data,
  input  logic [2:0] operation,
  input  logic       fun,
  input  logic       req_val,
  output logic       req_rdy,
  output logic [7:0] read_data,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic       resp_nack,
  output logic       resp_err,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  output logic [2:0] state_o
);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       fun_q, fun_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdat_q, wdat_d;
  logic [1:0] step_q, step_d;
  logic       pend_q, pend_d;
  logic       nack_q, nack_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
`ifdef I2C_CMD_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
`endif

  logic       go;
  logic       p_we;
  logic [2:0] p_adr;
  logic [7:0] p_wdat;
  logic       done;
  logic [7:0] rdat;
  logic       poll_ok;
  wb_step_t   stp;

  assign stp = seq_step(op_q, step_q, fun_q, addr_q, wdat_q, PRESCALE);
  // STOP waits for the bus to go idle; every other command waits for the byte transfer
  assign poll_ok = (op_q == OP_STOP) ? ~rdat[SR_BUSY] : ~rdat[SR_TIP];

  i2c_wb_port u_port (
    .clk      (clk),
    .reset    (reset),
    .go_i     (go),
    .we_i     (p_we),
    .adr_i    (p_adr),
    .wdat_i   (p_wdat),
    .done_o   (done),
    .rdat_o   (rdat),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fun_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      step_q  <= '0;
      pend_q  <= 1'b0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef I2C_CMD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fun_q   <= fun_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef I2C_CMD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; one bus access is issued whenever none is outstanding
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fun_d   = fun_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    step_d  = step_q;
    pend_d  = pend_q;
    nack_d  = nack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef I2C_CMD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    go     = 1'b0;
    p_we   = 1'b0;
    p_adr  = '0;
    p_wdat = '0;

    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          op_d   = operation;
          fun_d  = fun;
          addr_d = addr;
          wdat_d = write_data;
          step_d = '0;
          nack_d = 1'b0;
          err_d  = 1'b0;
          if (operation > OP_STOP) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WB_WR;
          end
        end
      end
      S_WB_WR: begin
        p_we   = 1'b1;
        p_adr  = stp.adr;
        p_wdat = stp.dat;
        go     = ~pend_q;
        if (done) begin
          if (stp.last) begin
            step_d  = '0;
            state_d = (op_q == OP_INITIALIZE) ? S_RESP : S_POLL;
`ifdef I2C_CMD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      S_POLL: begin
        p_adr = REG_SR;
        go    = ~pend_q;
`ifdef I2C_CMD_TIMEOUT_EN
        cnt_d = cnt_q + 24'd1;
`endif
        if (done) begin
          if (rdat[SR_AL]) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (poll_ok) begin
            if (op_q == OP_START || op_q == OP_WRITE) nack_d = rdat[SR_RXACK];
            state_d = (op_q == OP_READ) ? S_RD_RXR : S_RESP;
          end
`ifdef I2C_CMD_TIMEOUT_EN
          // Checked only at the end of an SR read so no access is left in flight
          else if (cnt_q >= TIMEOUT_CYCLES - 24'd1) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_RD_RXR: begin
        p_adr = REG_RXR;
        go    = ~pend_q;
        if (done) begin
          rdata_d = rdat;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) pend_d = 1'b0;
    if (go)   pend_d = 1'b1;
  end

  assign req_rdy   = (state_q == S_IDLE);
  assign resp_val  = (state_q == S_RESP);
  assign resp_nack = nack_q;
  assign resp_err  = err_q;
  assign read_data = rdata_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// Directed bench for i2c_cmd_engine with a behavioural i2c_master_top register
// model (programmable TIP/Busy poll counts, RxACK, AL and RXR).
module tb_i2c_cmd_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] addr;
  logic [7:0] write_data;
  logic [2:0] operation;
  logic       fun;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] read_data;
  logic       resp_val;
  logic       resp_rdy;
  logic       resp_nack;
  logic       resp_err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

`ifdef I2C_CMD_TIMEOUT_EN
  i2c_cmd_engine #(.TIMEOUT_CYCLES(24'd100)) dut (
`else
  i2c_cmd_engine dut (
`endif
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .operation(operation), .fun(fun), .req_val(req_val), .req_rdy(req_rdy),
    .read_data(read_data), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_nack(resp_nack), .resp_err(resp_err), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .state_o(dbg_state)
  );

  // core register model
  logic        ack_r = 1'b0;
  logic [7:0]  rdat_r = 8'h00;
  int          tip_left = 0;
  int          busy_left = 0;
  logic        rxack = 1'b0;
  logic        al = 1'b0;
  logic [7:0]  rxr = 8'h00;
  int          sr_reads = 0;
  logic        cyc_seen = 1'b0;
  logic [10:0] wr_log[$];
  logic [10:0] exp_q[$];

  assign wb_ack_i = ack_r;
  assign wb_dat_i = rdat_r;

  always @(posedge clk) begin
    if (wb_cyc_o) cyc_seen <= 1'b1;
    if (reset) begin
      ack_r  <= 1'b0;
      rdat_r <= 8'h00;
    end else if (wb_cyc_o && wb_stb_o && !ack_r) begin
      ack_r <= 1'b1;
      if (wb_we_o) begin
        wr_log.push_back({wb_adr_o, wb_dat_o});
      end else if (wb_adr_o == 3'd4) begin
        rdat_r   <= {rxack, busy_left != 0, al, 3'b000, tip_left != 0, 1'b0};
        sr_reads <= sr_reads + 1;
        if (tip_left > 0)  tip_left  <= tip_left - 1;
        if (busy_left > 0) busy_left <= busy_left - 1;
      end else if (wb_adr_o == 3'd3) begin
        rdat_r <= rxr;
      end else begin
        rdat_r <= 8'h00;
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (inputs change just after the falling edge)
  task automatic do_cmd(input logic [2:0] op, input logic f, input logic [6:0] a,
                        input logic [7:0] d);
    chk("req_rdy_before", {31'd0, req_rdy}, 1);
    operation  = op;
    fun        = f;
    addr       = a;
    write_data = d;
    req_val    = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    chk("req_rdy_after_accept", {31'd0, req_rdy}, 0);
  endtask

  task automatic wait_resp(input string tag, input int bound, output int n);
    n = 0;
    while (!resp_val && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_val"}, {31'd0, resp_val}, 1);
  endtask

  task automatic release_resp(input string tag);
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk({tag, "_idle_req_rdy"}, {31'd0, req_rdy}, 1);
    chk({tag, "_idle_resp_val"}, {31'd0, resp_val}, 0);
  endtask

  // scoreboard: expected register writes against the model's write log
  task automatic check_writes(input string tag);
    logic [10:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_log.size() > 0) chk(tag, {21'd0, wr_log.pop_front()}, {21'd0, e});
      else                   chk({tag, "_missing"}, 32'hFFFF_FFFF, {21'd0, e});
    end
    chk({tag, "_extra"}, wr_log.size(), 0);
  endtask

  int n;

  initial begin
    reset = 1'b1; addr = '0; write_data = '0; operation = '0; fun = 1'b0;
    req_val = 1'b0; resp_rdy = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_req_rdy",   {31'd0, req_rdy}, 1);
    chk("rst_resp_val",  {31'd0, resp_val}, 0);
    chk("rst_resp_nack", {31'd0, resp_nack}, 0);
    chk("rst_resp_err",  {31'd0, resp_err}, 0);
    chk("rst_read_data", {24'd0, read_data}, 0);
    chk("rst_wb_ctl",    {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0}, 0);
    chk("rst_wb_bus",    {21'd0, wb_adr_o, wb_dat_o}, 0);
    chk("rst_state",     {29'd0, dbg_state}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: INIT
    exp_q.push_back({3'd0, 8'h8F});
    exp_q.push_back({3'd1, 8'h01});
    exp_q.push_back({3'd2, 8'h80});
    do_cmd(3'd0, 1'b0, 7'h00, 8'h00);
    wait_resp("init", 300, n);
    chk("init_err", {31'd0, resp_err}, 0);
    chk("init_req_rdy_busy", {31'd0, req_rdy}, 0);
    check_writes("init_wr");
    release_resp("init");

    // 2: START addr 0x53 write, TIP for 10 polls, slave NACK
    tip_left = 10; rxack = 1'b1; sr_reads = 0;
    exp_q.push_back({3'd3, 8'hA6});
    exp_q.push_back({3'd4, 8'h90});
    do_cmd(3'd1, 1'b1, 7'h53, 8'h00);
    wait_resp("start", 500, n);
    chk("start_sr_reads", sr_reads, 11);
    chk("start_nack", {31'd0, resp_nack}, 1);
    chk("start_err",  {31'd0, resp_err}, 0);
    check_writes("start_wr");
    release_resp("start");

    // 3: READ with NACK, response held 5 cycles
    rxack = 1'b0; rxr = 8'h5A;
    exp_q.push_back({3'd4, 8'h28});
    do_cmd(3'd3, 1'b1, 7'h00, 8'h00);
    wait_resp("read", 300, n);
    for (int i = 0; i < 5; i++) begin
      chk("read_hold_val",  {31'd0, resp_val}, 1);
      chk("read_hold_data", {24'd0, read_data}, 32'h5A);
      chk("read_hold_err",  {31'd0, resp_err}, 0);
      @(negedge clk);
    end
    check_writes("read_wr");
    release_resp("read");

    // 4: WRITE 0x00 with STOP, then STOP with Busy for 3 polls
    exp_q.push_back({3'd3, 8'h00});
    exp_q.push_back({3'd4, 8'h50});
    do_cmd(3'd2, 1'b1, 7'h00, 8'h00);
    wait_resp("write", 300, n);
    chk("write_err",  {31'd0, resp_err}, 0);
    chk("write_nack", {31'd0, resp_nack}, 0);
    chk("write_keeps_read_data", {24'd0, read_data}, 32'h5A);
    check_writes("write_wr");
    release_resp("write");
    busy_left = 3; sr_reads = 0;
    exp_q.push_back({3'd4, 8'h40});
    do_cmd(3'd4, 1'b0, 7'h00, 8'h00);
    wait_resp("stop", 300, n);
    chk("stop_err", {31'd0, resp_err}, 0);
    chk("stop_sr_reads", sr_reads, 4);
    check_writes("stop_wr");
    release_resp("stop");

    // 5: illegal opcode, then arbitration lost during START poll
    cyc_seen = 1'b0;
    do_cmd(3'd7, 1'b0, 7'h00, 8'h00);
    wait_resp("badop", 1, n);
    chk("badop_err", {31'd0, resp_err}, 1);
    chk("badop_no_cyc", {31'd0, cyc_seen}, 0);
    release_resp("badop");
    al = 1'b1; tip_left = 5;
    exp_q.push_back({3'd3, 8'hA6});
    exp_q.push_back({3'd4, 8'h90});
    do_cmd(3'd1, 1'b1, 7'h53, 8'h00);
    wait_resp("al", 300, n);
    chk("al_err", {31'd0, resp_err}, 1);
    check_writes("al_wr");
    release_resp("al");
    al = 1'b0; tip_left = 0;

    // 6: reset in the middle of a poll
    tip_left = 1000; sr_reads = 0;
    do_cmd(3'd1, 1'b1, 7'h53, 8'h00);
    n = 0;
    while (sr_reads < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("midpoll_reached", {31'd0, sr_reads >= 3}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cyc",      {31'd0, wb_cyc_o}, 0);
    chk("midrst_req_rdy",  {31'd0, req_rdy}, 1);
    chk("midrst_resp_val", {31'd0, resp_val}, 0);
    @(negedge clk);
    reset = 1'b0; tip_left = 0; wr_log.delete(); exp_q.delete();
    @(negedge clk);
    exp_q.push_back({3'd4, 8'h40});
    do_cmd(3'd4, 1'b0, 7'h00, 8'h00);
    wait_resp("post_rst_stop", 300, n);
    chk("post_rst_stop_err", {31'd0, resp_err}, 0);
    check_writes("post_rst_stop_wr");
    release_resp("post_rst_stop");

`ifdef I2C_CMD_TIMEOUT_EN
    // poll watchdog with TIP stuck high
    tip_left = 1000000; sr_reads = 0;
    exp_q.push_back({3'd3, 8'hA6});
    exp_q.push_back({3'd4, 8'h90});
    do_cmd(3'd1, 1'b1, 7'h53, 8'h00);
    wait_resp("timeout", 3000, n);
    chk("timeout_err", {31'd0, resp_err}, 1);
    chk("timeout_late_enough", {31'd0, n >= 100}, 1);
    check_writes("timeout_wr");
    release_resp("timeout");
    tip_left = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
